// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive sweep sequencer for one combinational gate-under-test.
// On an accepted start it drives every input vector in ascending order, holds each
// for SETTLE cycles, samples the GUT output for one cycle, builds the observed truth
// table, counts mismatches against the selected reference and pulses done.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       sweep request and reference function (sampled in IDLE)
//   stim, dut_out   vector to the GUT and its output
//   busy, done      sweep in progress / one-cycle completion pulse
//   pass, bad_op    result flags, held until the next accepted start
//   truth, err_cnt  observed table and mismatch count
module gate_sweep_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   bad_op,
  output logic [(1<<N_IN)-1:0]   truth,
  output logic [N_IN:0]          err_cnt
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned IW = N_IN + 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN-1:0] stim_d;
  logic            busy_d, done_d, pass_d, bad_d;
  logic [NV-1:0]   truth_d;
  logic [IW-1:0]   err_d;
  logic            ref_bit;

  // Reference value for the vector currently being sampled
  always_comb begin
    ref_bit = 1'b0;
    case (op_q)
      OP_AND:  ref_bit = &idx_q[N_IN-1:0];
      OP_OR:   ref_bit = |idx_q[N_IN-1:0];
      OP_NAND: ref_bit = ~&idx_q[N_IN-1:0];
      OP_NOR:  ref_bit = ~|idx_q[N_IN-1:0];
      OP_XOR:  ref_bit = ^idx_q[N_IN-1:0];
      OP_XNOR: ref_bit = ~^idx_q[N_IN-1:0];
      default: ref_bit = 1'b0;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    stim_d  = stim;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    bad_d   = bad_op;
    truth_d = truth;
    err_d   = err_cnt;
    case (state_q)
      S_IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          idx_d   = '0;
          truth_d = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          bad_d   = 1'b0;
          busy_d  = 1'b1;
          if (op > OP_XNOR) begin
            // Illegal reference: report immediately without sweeping
            bad_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        truth_d[idx_q[N_IN-1:0]] = dut_out;
        if (dut_out != ref_bit) err_d = err_cnt + IW'(1);
        if (idx_q == IW'(NV - 1)) begin
          stim_d  = '0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          stim_d  = idx_d[N_IN-1:0];
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        stim_d  = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      stim    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      bad_op  <= 1'b0;
      truth   <= '0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      stim    <= stim_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      bad_op  <= bad_d;
      truth   <= truth_d;
      err_cnt <= err_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: scoreboard bench for gate_sweep_ctrl (N_IN=2, SETTLE=3).
// A behavioural GUT with selectable function and output lag drives dut_out.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [1:0] stim;
  logic       dut_out;
  logic       busy, done, pass, bad_op;
  logic [3:0] truth;
  logic [2:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] truth;
    logic [2:0] err;
    logic       pass;
    logic       bad;
  } exp_t;
  exp_t exp_q[$];

  int   gut_mode = 0;
  int   gut_lag  = 0;
  logic hist [0:7];

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .bad_op(bad_op), .truth(truth), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural gate-under-test: 0 NAND, 1 stuck-at-1, 2 a|~b
  function automatic logic gut_f(input int mode, input logic [1:0] s);
    case (mode)
      0:       return ~(s[1] & s[0]);
      1:       return 1'b1;
      default: return s[1] | ~s[0];
    endcase
  endfunction

  always @(posedge clk) begin
    hist[0] <= gut_f(gut_mode, stim);
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end

  always_comb dut_out = (gut_lag == 0) ? gut_f(gut_mode, stim) : hist[gut_lag-1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is compared against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = exp_q.pop_front();
        chk("truth", int'(truth), int'(e.truth));
        chk("err_cnt", int'(err_cnt), int'(e.err));
        chk("pass", int'(pass), int'(e.pass));
        chk("bad_op", int'(bad_op), int'(e.bad));
      end
    end
  end

  task automatic run_sweep(input logic [2:0] op_v, input int mode_v, input int lag_v,
                           input logic [3:0] t, input logic [2:0] e, input logic p,
                           input logic b, input int pulse_j);
    int   busy_n, done_n, done_at;
    bit   stim_ok;
    logic [1:0] exp_stim;
    gut_mode = mode_v;
    gut_lag  = lag_v;
    repeat (10) @(posedge clk);
    exp_q.push_back('{truth: t, err: e, pass: p, bad: b});
    @(negedge clk);
    start = 1'b1;
    op    = op_v;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; stim_ok = 1'b1;
    for (int j = 0; j < 40; j++) begin
      start = (j == pulse_j);
      if (!busy) break;
      busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      exp_stim = (b || j >= 16) ? 2'd0 : 2'(j / 4);
      if (stim !== exp_stim) stim_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_cycles", busy_n, b ? 1 : 17);
    chk("done_cycles", done_n, 1);
    chk("done_time", done_at, b ? 0 : 16);
    chk("stim_sequence", int'(stim_ok), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_outputs", int'({stim, done, pass, bad_op, truth, err_cnt}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(3'd2, 0, 0, 4'b0111, 3'd0, 1'b1, 1'b0, -1);  // NAND, op NAND
    chk("pass_held_idle", int'(pass), 1);
    run_sweep(3'd0, 1, 0, 4'b1111, 3'd3, 1'b0, 1'b0, -1);  // stuck-at-1, op AND
    run_sweep(3'd4, 2, 0, 4'b1101, 3'd3, 1'b0, 1'b0, -1);  // a|~b, op XOR
    run_sweep(3'd7, 0, 0, 4'b0000, 3'd0, 1'b0, 1'b1, -1);  // illegal op
    chk("bad_op_held", int'(bad_op), 1);
    run_sweep(3'd2, 0, 0, 4'b0111, 3'd0, 1'b1, 1'b0, -1);  // clears bad_op
    run_sweep(3'd2, 0, 3, 4'b0111, 3'd0, 1'b1, 1'b0, -1);  // lag == SETTLE
    run_sweep(3'd2, 0, 4, 4'b1111, 3'd1, 1'b0, 1'b0, -1);  // lag == SETTLE+1

    // Reset in the middle of a sweep: outputs clear at once, no done pulse
    gut_lag = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_stim", int'(stim), 0);
    chk("mid_reset_outputs", int'({done, pass, bad_op, truth, err_cnt}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep with a spurious start during busy; it must be ignored
    run_sweep(3'd2, 0, 0, 4'b0111, 3'd0, 1'b1, 1'b0, 5);
    begin
      int busy_seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (busy) busy_seen++;
      end
      chk("no_queued_sweep", busy_seen, 0);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
